// File: rtl/sorter8_pkg.sv
// Shared definitions for the sorter8 frame sorter: FSM state encoding
// and default frame geometry.
package sorter8_pkg;

   localparam int DEPTH_DEF = 8;
   localparam int W_DEF     = 8;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/sorter8_minmax_cell.sv
// Signed compare-exchange: lo gets the smaller of a/b, hi the larger.
// Equal inputs pass straight through unswapped.
module minmax_cell #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] lo,
   output logic [W-1:0] hi
);

   logic b_less;

   // Differing signs: the negative one is smaller; otherwise the magnitude bits decide.
   always_comb begin
      b_less = 1'b0;
      if (a[W-1] != b[W-1]) begin
         b_less = b[W-1];
      end else begin
         b_less = (b[W-2:0] < a[W-2:0]);
      end
   end

   assign lo = b_less ? b : a;
   assign hi = b_less ? a : b;

endmodule

// File: rtl/sorter8.sv
// Frame sorter: loads DEPTH signed samples, sorts them with DEPTH passes of
// odd-even transposition, then streams them out ascending.
module sorter8
   import sorter8_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W     = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy,
   output logic [1:0]   state_dbg
);

   // Handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; valid and data hold steady until that transfer.

   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] rd;
   logic [CW-1:0] pass;
   logic          valid_q;
   logic          in_fire;
   logic          out_fire;

   logic [W-1:0]  mem     [DEPTH];
   logic [W-1:0]  even_nx [DEPTH];
   logic [W-1:0]  odd_nx  [DEPTH];

   assign in_ready = (state == LOAD) & ~rst;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = valid_q & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         LOAD:    if (in_fire && cnt == LAST) state_nx = SORT;
         SORT:    if (pass == LAST) state_nx = DRAIN;
         DRAIN:   if (out_fire && rd == LAST) state_nx = LOAD;
         default: state_nx = LOAD;
      endcase
   end

   // out_valid is registered so it rises one cycle after entering DRAIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         rd      <= '0;
         pass    <= '0;
         valid_q <= 1'b0;
      end else begin
         if (in_fire) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
         end
         if (state == SORT) begin
            pass <= (pass == LAST) ? '0 : pass + 1'b1;
         end
         if (out_fire) begin
            rd <= (rd == LAST) ? '0 : rd + 1'b1;
         end
         valid_q <= (state == DRAIN) && !(out_fire && rd == LAST);
      end
   end

   for (genvar i = 0; i < DEPTH / 2; i++) begin : g_even
      minmax_cell #(.W(W)) u_cell (
         .a  (mem[2*i]),
         .b  (mem[2*i+1]),
         .lo (even_nx[2*i]),
         .hi (even_nx[2*i+1])
      );
   end

   for (genvar i = 0; i < DEPTH / 2 - 1; i++) begin : g_odd
      minmax_cell #(.W(W)) u_cell (
         .a  (mem[2*i+1]),
         .b  (mem[2*i+2]),
         .lo (odd_nx[2*i+1]),
         .hi (odd_nx[2*i+2])
      );
   end

   // End slots have no partner on odd passes.
   assign odd_nx[0]       = mem[0];
   assign odd_nx[DEPTH-1] = mem[DEPTH-1];

   // Sample buffer needs no reset: every slot is rewritten before it is read.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem[cnt] <= in_data;
      end else if (state == SORT) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= pass[0] ? odd_nx[i] : even_nx[i];
         end
      end
   end

   assign out_valid = valid_q;
   assign out_data  = mem[rd];
   assign out_last  = valid_q & (rd == LAST);
   assign busy      = (state == SORT) | (state == DRAIN);
   assign state_dbg = state;

endmodule

// File: tb/tb_sorter8.sv
// Directed bench for sorter8: table of frames with hand-sorted results,
// plus stall, held-valid, back-to-back and reset-abort sequences.
module tb_sorter8;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic [1:0] state_dbg;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] in_v;
      logic [63:0] exp_v;
   } vec_t;

   vec_t tbl [6];

   sorter8 #(.DEPTH(8), .W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic logic [63:0] pk(input logic [7:0] b0, b1, b2, b3,
                                      input logic [7:0] b4, b5, b6, b7);
      return {b7, b6, b5, b4, b3, b2, b1, b0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("in_ready_in_rst", {31'b0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_last", {31'b0, out_last}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_state", {30'b0, state_dbg}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Presents n samples back to back; hold_valid keeps in_valid high with junk after.
   task automatic load_frame(input logic [63:0] v, input int n, input bit hold_valid);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = v[8*i +: 8];
         @(negedge clk);
         chk("load_in_ready", {31'b0, in_ready}, 32'd1);
         @(posedge clk);
         #1;
      end
      in_data = 8'h55;
      if (!hold_valid) in_valid = 1'b0;
   endtask

   // Counts edges from the last accept to the first out_valid.
   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         chk("sort_in_ready", {31'b0, in_ready}, 32'd0);
         chk("sort_busy", {31'b0, busy}, 32'd1);
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, 32'd9);
   endtask

   task automatic drain(input logic [63:0] exp_v, input bit rnd_ready, input int n_take);
      int k;
      int guard;
      k = 0;
      guard = 0;
      while (k < n_take && guard < 200) begin
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         chk("drain_valid", {31'b0, out_valid}, 32'd1);
         chk("drain_data", {24'b0, out_data}, {24'b0, exp_v[8*k +: 8]});
         chk("drain_last", {31'b0, out_last}, (k == 7) ? 32'd1 : 32'd0);
         if (out_ready) k++;
         @(posedge clk);
         #1;
         guard++;
      end
      chk("drain_timeout", guard < 200 ? 32'd0 : 32'd1, 32'd0);
      out_ready = 1'b0;
   endtask

   task automatic check_idle_after_frame();
      chk("post_in_ready", {31'b0, in_ready}, 32'd1);
      chk("post_out_valid", {31'b0, out_valid}, 32'd0);
      chk("post_out_last", {31'b0, out_last}, 32'd0);
      chk("post_busy", {31'b0, busy}, 32'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      tbl[0].in_v  = pk(8'h07, 8'hFD, 8'h7F, 8'h80, 8'h00, 8'h05, 8'hFF, 8'h02);
      tbl[0].exp_v = pk(8'h80, 8'hFD, 8'hFF, 8'h00, 8'h02, 8'h05, 8'h07, 8'h7F);
      tbl[1].in_v  = pk(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
      tbl[1].exp_v = pk(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
      tbl[2].in_v  = pk(8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01);
      tbl[2].exp_v = pk(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
      tbl[3].in_v  = pk(8'h03, 8'h03, 8'hFD, 8'hFD, 8'h03, 8'hFD, 8'h03, 8'hFD);
      tbl[3].exp_v = pk(8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'h03, 8'h03, 8'h03, 8'h03);
      tbl[4].in_v  = pk(8'h7F, 8'h80, 8'h00, 8'hFF, 8'h01, 8'hFE, 8'h81, 8'h7E);
      tbl[4].exp_v = pk(8'h80, 8'h81, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h7E, 8'h7F);
      tbl[5].in_v  = pk(8'h10, 8'hF0, 8'h10, 8'h00, 8'h7F, 8'h80, 8'hFF, 8'h01);
      tbl[5].exp_v = pk(8'h80, 8'hF0, 8'hFF, 8'h00, 8'h01, 8'h10, 8'h10, 8'h7F);

      do_reset();

      // Table of frames, free-flowing output.
      for (int t = 0; t < 6; t++) begin
         load_frame(tbl[t].in_v, 8, 1'b0);
         wait_valid();
         drain(tbl[t].exp_v, 1'b0, 8);
         check_idle_after_frame();
      end

      // Random backpressure: data must be stable while stalled, no drops or repeats.
      load_frame(tbl[0].in_v, 8, 1'b0);
      wait_valid();
      drain(tbl[0].exp_v, 1'b1, 8);
      check_idle_after_frame();

      // in_valid held through SORT/DRAIN, then next frame with zero idle cycles.
      load_frame(tbl[4].in_v, 8, 1'b1);
      wait_valid();
      drain(tbl[4].exp_v, 1'b0, 8);
      check_idle_after_frame();
      load_frame(tbl[2].in_v, 8, 1'b0);
      wait_valid();
      drain(tbl[2].exp_v, 1'b0, 8);
      check_idle_after_frame();

      // Reset after 4 inputs, then a fresh frame.
      load_frame(tbl[1].in_v, 4, 1'b0);
      do_reset();
      load_frame(tbl[5].in_v, 8, 1'b0);
      wait_valid();
      drain(tbl[5].exp_v, 1'b0, 8);
      check_idle_after_frame();

      // Reset mid-DRAIN: no further output, then a fresh frame.
      load_frame(tbl[3].in_v, 8, 1'b0);
      wait_valid();
      drain(tbl[3].exp_v, 1'b0, 3);
      do_reset();
      out_ready = 1'b1;
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_valid", {31'b0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      load_frame(tbl[0].in_v, 8, 1'b0);
      wait_valid();
      drain(tbl[0].exp_v, 1'b0, 8);
      check_idle_after_frame();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sorter8.md
SORTER8 -- requirements
Module: sorter8

Interface
REQ-001 Parameter: DEPTH, 8, number of samples per frame; even, >=2.
REQ-002 Parameter: W, 8, sample width in bits, two's-complement signed.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream sample valid.
REQ-006 in_ready  output  1  block accepts a sample this cycle.
REQ-007 in_data  input  W  signed sample.
REQ-008 out_valid  output  1  sorted sample valid.
REQ-009 out_ready  input  1  downstream accepts the sample.
REQ-010 out_data  output  W  sorted sample, ascending (minimum first).
REQ-011 out_last  output  1  high with the DEPTH-th output sample of a frame.
REQ-012 busy  output  1  high in SORT or DRAIN.

Function
REQ-013 The block SHALL have three states: LOAD, SORT and DRAIN.
REQ-014 LOAD: in_ready=1; each cycle with in_valid&in_ready writes in_data to buffer[cnt], cnt++; the DEPTH-th accept moves to SORT with cnt cleared.
REQ-015 SORT: in_ready=0; DEPTH cycles of odd-even transposition; pass p (0..DEPTH-1) compare-exchanges pairs (i,i+1) with i even when p even and i odd when p odd; all pairs of a pass update in one cycle.
REQ-016 Compare-exchange SHALL place the signed minimum at the lower index; the compare uses the sign bit when signs differ and the magnitude bits otherwise (-128 < -1 < 0 < 127); equal values are left in place.
REQ-017 After pass DEPTH-1 the block SHALL enter DRAIN; out_valid rises the following cycle, DEPTH+1 cycles after the last input accept.
REQ-018 DRAIN: out_data=buffer[rd]; out_valid=1; advance rd only on out_valid&out_ready; out_data, out_valid and out_last SHALL hold while out_ready=0.
REQ-019 out_last=1 iff rd==DEPTH-1 in DRAIN; the accept of that sample returns to LOAD with rd=0, in_ready=1 on the next cycle.
REQ-020 No input is accepted during SORT or DRAIN; in_valid during those states SHALL be ignored without loss of state.
REQ-021 Back-to-back frames: zero idle cycles required between the last output accept and the first input accept of the next frame.
REQ-022 out_valid=0 and out_last=0 outside DRAIN; busy=1 exactly in SORT and DRAIN.
REQ-023 Counters cnt, rd (clog2(DEPTH) bits) and the pass counter SHALL never wrap within a state; they clear on state exit.

Reset
REQ-024 rst=1 SHALL force state LOAD, cnt=rd=pass=0, out_valid=0, out_last=0, busy=0, in_ready=1 on the cycle after rst deasserts; buffer contents need not be cleared.
REQ-025 Reset asserted mid-frame (any state) SHALL abort the frame; no partial output is emitted afterwards.
REQ-026 in_ready SHALL be 0 while rst=1.

Structure
REQ-027 A shared package SHALL hold the state enumeration (LOAD, SORT, DRAIN) and the DEPTH/W defaults.
REQ-028 The compare-exchange SHALL be a sub-module minmax_cell (inputs a, b [W]; outputs lo, hi), instantiated DEPTH/2 times for even passes and DEPTH/2-1 times for odd passes.

Verification
REQ-029 Load 7,-3,127,-128,0,5,-1,2 -> out 0x80,0xFD,0xFF,0x00,0x02,0x05,0x07,0x7F; out_last on 0x7F only; first out_valid 9 cycles after the 8th accept.
REQ-030 Already-sorted 1..8 and reverse 8..1 -> both output 1..8; duplicates 3,3,-3,-3,3,-3,3,-3 -> -3 x4 then 3 x4.
REQ-031 out_ready toggled randomly during DRAIN -> out_data stable while stalled, 8 samples, no drops or repeats.
REQ-032 in_valid held high through SORT/DRAIN -> in_ready=0, no buffer corruption; next frame starts the cycle after the out_last accept.
REQ-033 rst pulsed after 4 inputs, and again mid-DRAIN -> out_valid=0, in_ready=1 after release; fresh 8-sample frame sorts correctly.
REQ-034 Boundary pair values 0x7F vs 0x80 and 0x00 vs 0xFF in adjacent slots -> 0x80 before 0xFF before 0x00 before 0x7F.
